// File: rtl/uart_packet_parser_if.sv
// Byte stream arriving from async_receiver and the addressed write strike leaving
// toward the loader; the parser sits on the slave side of this bundle.
interface uart_packet_parser_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic [7:0] data_out;
    logic [7:0] addr_out;
    logic       write_tick;
    logic       success_tick;
    logic       error_tick;

    modport master (
        output rx_ready, rx_data,
        input  data_out, addr_out, write_tick, success_tick, error_tick
    );

    modport slave (
        input  rx_ready, rx_data,
        output data_out, addr_out, write_tick, success_tick, error_tick
    );
endinterface

// File: rtl/uart_packet_parser.sv
// Frames checksum|address|count|data bytes into addressed write strikes and flags the
// packet good or bad on its last byte. Define PARSER_TIMEOUT_EN for an inter-byte gap timeout.
module uart_packet_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned TIMEOUT_W      = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  en,
    uart_packet_parser_if.slave   bus,
    output logic [7:0]            current_state,
    output logic [7:0]            current_count
);

    typedef enum logic [1:0] {
        S_CKSUM = 2'd0,
        S_ADDR  = 2'd1,
        S_COUNT = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [7:0] sum, sum_next;
    logic [7:0] count, count_next;
    logic [7:0] addr_q, addr_next;
    logic [7:0] data_q, data_next;
    logic       write_q, write_next;
    logic       success_q, success_next;
    logic       error_q, error_next;
    logic [7:0] sum_add;
    logic       accept;
    logic       timeout_hit;

    assign accept  = bus.rx_ready & en & ~restart;
    assign sum_add = sum + bus.rx_data;

`ifdef PARSER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] gap;
    logic [TIMEOUT_W-1:0] gap_inc;

    assign gap_inc     = gap + 1'b1;
    assign timeout_hit = (state != S_CKSUM) && en && !accept && !restart
                         && (gap_inc == TIMEOUT_W'(TIMEOUT_CYCLES));

    // The gap only runs while a packet is open and the loader is enabling us.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap <= '0;
        end else if (restart || accept || timeout_hit || state == S_CKSUM) begin
            gap <= '0;
        end else if (en) begin
            gap <= gap_inc;
        end
    end
`else
    logic [TIMEOUT_W-1:0] unused_timeout;

    assign unused_timeout = TIMEOUT_W'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_CKSUM;
            sum       <= '0;
            count     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            success_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_next;
            sum       <= sum_next;
            count     <= count_next;
            addr_q    <= addr_next;
            data_q    <= data_next;
            write_q   <= write_next;
            success_q <= success_next;
            error_q   <= error_next;
        end
    end

    // restart outranks a coincident byte; the timeout only fires on an idle cycle.
    always_comb begin
        state_next   = state;
        sum_next     = sum;
        count_next   = count;
        addr_next    = addr_q;
        data_next    = data_q;
        write_next   = 1'b0;
        success_next = 1'b0;
        error_next   = 1'b0;

        if (restart) begin
            state_next = S_CKSUM;
            sum_next   = '0;
            count_next = '0;
        end else if (accept) begin
            case (state)
                S_CKSUM: begin
                    sum_next   = bus.rx_data;
                    state_next = S_ADDR;
                end
                S_ADDR: begin
                    addr_next  = bus.rx_data;
                    sum_next   = sum_add;
                    state_next = S_COUNT;
                end
                S_COUNT: begin
                    count_next = bus.rx_data;
                    sum_next   = sum_add;
                    state_next = S_DATA;
                end
                S_DATA: begin
                    data_next  = bus.rx_data;
                    write_next = 1'b1;
                    if (count != 8'd0) begin
                        count_next = count - 8'd1;
                        sum_next   = sum_add;
                    end else begin
                        success_next = (sum_add == 8'd0);
                        error_next   = (sum_add != 8'd0);
                        sum_next     = '0;
                        state_next   = S_CKSUM;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_next = S_CKSUM;
            sum_next   = '0;
            count_next = '0;
            error_next = 1'b1;
        end
    end

    assign bus.addr_out     = addr_q;
    assign bus.data_out     = data_q;
    assign bus.write_tick   = write_q;
    assign bus.success_tick = success_q;
    assign bus.error_tick   = error_q;
    assign current_state    = {6'b0, state};
    assign current_count    = count;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: stimulus pushes expected strikes, a negedge
// monitor pops and compares them whenever any tick is presented.
module tb_uart_packet_parser;

   typedef struct {
      logic       wr;
      logic       ok;
      logic       bad;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       restart = 1'b0;
   logic       en = 1'b0;
   logic [7:0] current_state;
   logic [7:0] current_count;
   int         checks = 0;
   int         errors = 0;
   exp_t       exp_q[$];

   uart_packet_parser_if bus();

   uart_packet_parser #(
      .TIMEOUT_CYCLES(16),
      .TIMEOUT_W(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .restart(restart),
      .en(en),
      .bus(bus.slave),
      .current_state(current_state),
      .current_count(current_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drives one byte for exactly one accepting edge, returning #1 after that edge.
   task automatic applyStimulus(input logic [7:0] b);
      bus.rx_ready = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
      #1;
      bus.rx_ready = 1'b0;
   endtask

   task automatic pushExp(input logic wr, input logic ok, input logic bad,
                          input logic [7:0] addr, input logic [7:0] data);
      exp_t e;
      e.wr = wr; e.ok = ok; e.bad = bad; e.addr = addr; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
      checkOutput(name, 16'(exp_q.size()), 16'd0);
      exp_q.delete();
   endtask

   task automatic sendSmall(input logic [7:0] ck, input logic good);
      pushExp(1'b1, 1'b0, 1'b0, 8'h10, 8'hAA);
      pushExp(1'b1, good, !good, 8'h10, 8'h55);
      applyStimulus(ck);
      applyStimulus(8'h10);
      applyStimulus(8'h01);
      applyStimulus(8'hAA);
      applyStimulus(8'h55);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (bus.write_tick || bus.success_tick || bus.error_tick)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_tick actual=w%b s%b e%b required=none",
                        bus.write_tick, bus.success_tick, bus.error_tick);
            end else begin
               e = exp_q.pop_front();
               checkOutput("write_tick", 16'(bus.write_tick), 16'(e.wr));
               checkOutput("success_tick", 16'(bus.success_tick), 16'(e.ok));
               checkOutput("error_tick", 16'(bus.error_tick), 16'(e.bad));
               if (e.wr) begin
                  checkOutput("addr_out", 16'(bus.addr_out), 16'(e.addr));
                  checkOutput("data_out", 16'(bus.data_out), 16'(e.data));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      bus.rx_ready = 1'b0;
      bus.rx_data  = 8'h00;
      #12;
      checkOutput("reset_state", 16'(current_state), 16'd0);
      checkOutput("reset_count", 16'(current_count), 16'd0);
      checkOutput("reset_addr", 16'(bus.addr_out), 16'd0);
      checkOutput("reset_data", 16'(bus.data_out), 16'd0);
      checkOutput("reset_ticks", 16'({bus.write_tick, bus.success_tick, bus.error_tick}), 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // en low: bytes dropped, state held
      applyStimulus(8'hF0);
      applyStimulus(8'h10);
      checkOutput("en_low_state", 16'(current_state), 16'd0);
      repeat (3) @(posedge clk);
      #1;
      en = 1'b1;

      $display("[TB] good packet");
      sendSmall(8'hF0, 1'b1);
      checkOutput("good_state", 16'(current_state), 16'd0);
      waitDrain("good_drain");

      $display("[TB] bad checksum");
      sendSmall(8'hF1, 1'b0);
      checkOutput("bad_state", 16'(current_state), 16'd0);
      waitDrain("bad_drain");

      $display("[TB] max length");
      applyStimulus(8'h71);
      applyStimulus(8'h10);
      applyStimulus(8'hFF);
      checkOutput("max_count_start", 16'(current_count), 16'h00FF);
      for (int i = 0; i < 256; i++) begin
         pushExp(1'b1, i == 255, 1'b0, 8'h10, 8'(i));
         applyStimulus(8'(i));
         if (i < 255) checkOutput("max_count_dec", 16'(current_count), 16'(8'hFE - 8'(i)));
      end
      checkOutput("max_state", 16'(current_state), 16'd0);
      waitDrain("max_drain");

      $display("[TB] restart coincident with byte");
      applyStimulus(8'hF0);
      applyStimulus(8'h10);
      applyStimulus(8'h01);
      checkOutput("pre_restart_state", 16'(current_state), 16'd3);
      bus.rx_ready = 1'b1;
      bus.rx_data  = 8'hAA;
      restart      = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_ready = 1'b0;
      restart      = 1'b0;
      checkOutput("restart_state", 16'(current_state), 16'd0);
      checkOutput("restart_count", 16'(current_count), 16'd0);
      repeat (2) @(posedge clk);
      #1;
      sendSmall(8'hF0, 1'b1);
      waitDrain("restart_drain");

      $display("[TB] back to back");
      sendSmall(8'hF0, 1'b1);
      sendSmall(8'hF0, 1'b1);
      checkOutput("b2b_state", 16'(current_state), 16'd0);
      waitDrain("b2b_drain");

      $display("[TB] gap handling");
`ifdef PARSER_TIMEOUT_EN
      pushExp(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      applyStimulus(8'hF0);
      applyStimulus(8'h10);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("timeout_state", 16'(current_state), 16'd0);
      waitDrain("timeout_drain");
`else
      applyStimulus(8'hF0);
      applyStimulus(8'h10);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("no_timeout_state", 16'(current_state), 16'd2);
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      checkOutput("gap_restart_state", 16'(current_state), 16'd0);
`endif

      $display("[TB] async reset mid packet");
      applyStimulus(8'hF0);
      applyStimulus(8'h10);
      applyStimulus(8'h01);
      pushExp(1'b1, 1'b0, 1'b0, 8'h10, 8'hAA);
      applyStimulus(8'hAA);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #2;
      checkOutput("areset_state", 16'(current_state), 16'd0);
      checkOutput("areset_count", 16'(current_count), 16'd0);
      checkOutput("areset_addr", 16'(bus.addr_out), 16'd0);
      checkOutput("areset_ticks", 16'({bus.write_tick, bus.success_tick, bus.error_tick}), 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(8'h55);
      checkOutput("post_reset_state", 16'(current_state), 16'd1);
      repeat (3) @(posedge clk);
      waitDrain("areset_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
